// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles each 32-bit instruction from four byte reads
// and presents {pc, inst} to IF/ID with busy/valid handshaking, stalls and jumps.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic        if_busy_o,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        dbg_state_o
);

  // Handshakes: a byte request is taken when mem_req_o && mem_ack_i at a rising
  // edge, and its data is on mem_data_i in the following cycle. IF/ID takes the
  // presented pair on an edge where if_busy_o == 0 and stall_i == 0.
  typedef enum logic {
    S_FETCH = 1'b0,
    S_VALID = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic        rd_pending_q, rd_pending_d;
  logic        jump_pend_q, jump_pend_d;
  logic [31:0] jump_tgt_q, jump_tgt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        req;
  logic        accept;

  assign req    = (state_q == S_FETCH) && (issue_cnt_q < 3'd4);
  assign accept = req && mem_ack_i;

  // Gated by rst so the bus goes quiet in the same cycle reset is raised.
  assign mem_req_o   = req && !rst;
  assign mem_addr_o  = rst ? 32'h0 : (pc_q + {29'b0, issue_cnt_q});
  assign if_busy_o   = (state_q != S_VALID);
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      issue_cnt_q  <= 3'd0;
      recv_cnt_q   <= 3'd0;
      rd_pending_q <= 1'b0;
      jump_pend_q  <= 1'b0;
      jump_tgt_q   <= 32'h0;
      asm_q        <= 32'h0;
      if_pc_q      <= 32'h0;
      if_inst_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      rd_pending_q <= rd_pending_d;
      jump_pend_q  <= jump_pend_d;
      jump_tgt_q   <= jump_tgt_d;
      asm_q        <= asm_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    rd_pending_d = accept;
    jump_pend_d  = jump_pend_q;
    jump_tgt_d   = jump_tgt_q;
    asm_d        = asm_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;

    if (accept) begin
      issue_cnt_d = issue_cnt_q + 3'd1;
    end

    if (rd_pending_q) begin
      asm_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_data_i;
      recv_cnt_d = recv_cnt_q + 3'd1;
      if (recv_cnt_q == 3'd3) begin
        state_d   = S_VALID;
        if_pc_d   = pc_q;
        if_inst_d = {mem_data_i, asm_q[23:0]};
      end
    end

    if (state_q == S_VALID && !stall_i) begin
      state_d     = S_FETCH;
      issue_cnt_d = 3'd0;
      recv_cnt_d  = 3'd0;
      pc_d        = jump_pend_q ? jump_tgt_q : (pc_q + 32'd4);
      jump_pend_d = 1'b0;
    end

    // Placed last: a jump seen on the consuming edge must survive the clear above.
    if (jump_i) begin
      jump_pend_d = 1'b1;
      jump_tgt_d  = jump_addr_i;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte-wide memory model, delivery scoreboard,
// and inline checks of request addresses, stalls, jumps and reset.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic        if_busy_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic        prev_busy = 1'b1;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .jump_i      (jump_i),
    .jump_addr_i (jump_addr_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_data_i  (mem_data_i),
    .if_busy_o   (if_busy_o),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .dbg_state_o (dbg_state_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = exp_word({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  // Memory: accepted byte appears in the next cycle, otherwise noise.
  always @(posedge clk) begin
    if (mem_req_o && mem_ack_i) mem_data_i <= mem_byte(mem_addr_o);
    else                        mem_data_i <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, exp_word(pc)});
  endtask

  task automatic wait_valid(input int budget);
    for (int n = 0; n < budget && if_busy_o; n++) tick();
    chk("wait_valid_busy", {31'b0, if_busy_o}, 32'd0);
  endtask

  // Scoreboard: each new presentation pops one expected {pc, inst}.
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b1;
    end else begin
      if (!if_busy_o && prev_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected: observed pc=%h expected=no delivery", if_pc);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("deliv_pc", if_pc, e[63:32]);
          chk("deliv_inst", if_inst, e[31:0]);
        end
      end
      prev_busy = if_busy_o;
    end
  end

  initial begin
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   off [7] = '{0, 1, 1, 1, 2, 3, 3};
    rst = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = 32'h0; mem_ack_i = 1'b0;
    repeat (2) tick();

    // Reset values
    chk("rst_busy", {31'b0, if_busy_o}, 32'd1);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_state", {31'b0, dbg_state_o}, 32'd0);

    // First fetch, continuous acks
    push_exp(32'h0);
    rst = 1'b0; mem_ack_i = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("c0_req", {31'b0, mem_req_o}, 32'd1);
      chk("c0_addr", mem_addr_o, 32'(k));
      tick();
    end
    chk("c4_req_low", {31'b0, mem_req_o}, 32'd0);
    chk("c4_busy", {31'b0, if_busy_o}, 32'd1);
    tick();
    chk("c5_busy", {31'b0, if_busy_o}, 32'd0);
    tick();

    // Second sequential fetch
    push_exp(32'h4);
    chk("c6_busy", {31'b0, if_busy_o}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("seq2_req", {31'b0, mem_req_o}, 32'd1);
      chk("seq2_addr", mem_addr_o, 32'h4 + 32'(k));
      tick();
    end
    chk("seq2_req_low", {31'b0, mem_req_o}, 32'd0);
    tick();
    chk("seq2_busy0", {31'b0, if_busy_o}, 32'd0);
    tick();
    chk("seq2_busy1", {31'b0, if_busy_o}, 32'd1);

    // Ack gaps on pc 8
    push_exp(32'h8);
    for (int i = 0; i < 7; i++) begin
      mem_ack_i = pat[i];
      chk("gap_req", {31'b0, mem_req_o}, 32'd1);
      chk("gap_addr", mem_addr_o, 32'h8 + 32'(off[i]));
      tick();
    end
    mem_ack_i = 1'b1;
    chk("gap_req_low", {31'b0, mem_req_o}, 32'd0);
    chk("gap_busy_late", {31'b0, if_busy_o}, 32'd1);
    tick();
    chk("gap_busy0", {31'b0, if_busy_o}, 32'd0);
    tick();

    // Stall over the VALID of pc 0xC
    push_exp(32'hC);
    chk("stall_addr", mem_addr_o, 32'hC);
    wait_valid(20);
    stall_i = 1'b1;
    for (int v = 0; v < 4; v++) begin
      if (v == 3) stall_i = 1'b0;
      chk("stall_busy", {31'b0, if_busy_o}, 32'd0);
      chk("stall_pc", if_pc, 32'hC);
      chk("stall_inst", if_inst, exp_word(32'hC));
      chk("stall_req", {31'b0, mem_req_o}, 32'd0);
      tick();
    end
    chk("post_stall_req", {31'b0, mem_req_o}, 32'd1);
    chk("post_stall_addr", mem_addr_o, 32'h10);

    // Jump during fetch of 0x10
    push_exp(32'h10);
    push_exp(32'h100);
    tick(); tick();
    jump_i = 1'b1; jump_addr_i = 32'h100;
    tick();
    jump_i = 1'b0;
    wait_valid(20);
    tick();
    chk("jmp1_addr", mem_addr_o, 32'h100);
    wait_valid(20);

    // Jump in unstalled VALID of 0x100: 0x104 is wrong path, then 0x200
    push_exp(32'h104);
    push_exp(32'h200);
    jump_i = 1'b1; jump_addr_i = 32'h200;
    tick();
    jump_i = 1'b0;
    chk("jmp2_seq_addr", mem_addr_o, 32'h104);
    wait_valid(20);
    tick();
    chk("jmp2_tgt_addr", mem_addr_o, 32'h200);
    wait_valid(20);
    tick();

    // Random acks on 0x204 with an overwritten jump target
    push_exp(32'h204);
    push_exp(32'h400);
    for (int n = 0; n < 60 && if_busy_o; n++) begin
      jump_i      = (n == 1) || (n == 3);
      jump_addr_i = (n == 1) ? 32'h300 : 32'h400;
      mem_ack_i   = 1'($urandom_range(0, 1));
      tick();
    end
    jump_i = 1'b0; mem_ack_i = 1'b1;
    chk("rand_busy", {31'b0, if_busy_o}, 32'd0);
    tick();
    chk("jmp3_addr", mem_addr_o, 32'h400);
    wait_valid(20);
    tick();

    // Reset after two bytes of 0x404 accepted, with a jump pending
    jump_i = 1'b1; jump_addr_i = 32'h300;
    tick();
    jump_i = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, if_busy_o}, 32'd1);
    chk("mid_rst_pc", if_pc, 32'h0);
    chk("mid_rst_inst", if_inst, 32'h0);
    chk("mid_rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("mid_rst_addr", mem_addr_o, 32'h0);
    tick(); tick();
    push_exp(32'h0);
    push_exp(32'h4);
    rst = 1'b0;
    #1;
    chk("rerun_req", {31'b0, mem_req_o}, 32'd1);
    chk("rerun_addr", mem_addr_o, 32'h0);
    wait_valid(20);
    tick();
    chk("rerun_next_addr", mem_addr_o, 32'h4);
    wait_valid(20);
    tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
